// File: rtl/regfile_gen2.sv
// Byte-addressable register file with paired 2*DATA_W address registers that
// can be loaded, incremented or decremented, plus optional write-through reads.
module regfile_gen2 #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 8,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MAIN_LOAD_bar,
  input  logic [SEL_W-1:0]    MAIN_LOAD_SEL,
  input  logic [DATA_W-1:0]   MAIN_in,
  input  logic                ADDR_LOAD_bar,
  input  logic [SEL_W-2:0]    ADDR_LOAD_SEL,
  input  logic [2*DATA_W-1:0] ADDR_in,
  input  logic                ADDR_INC,
  input  logic                ADDR_DEC,
  input  logic [SEL_W-2:0]    ADDR_INC_SEL,
  input  logic [SEL_W-1:0]    MAIN_ASSERT_SEL,
  input  logic [SEL_W-1:0]    LHS_ASSERT_SEL,
  input  logic [SEL_W-1:0]    RHS_ASSERT_SEL,
  input  logic [SEL_W-2:0]    ADDR_ASSERT_SEL,
  output logic [DATA_W-1:0]   MAIN_out,
  output logic [DATA_W-1:0]   LHS_out,
  output logic [DATA_W-1:0]   RHS_out,
  output logic [2*DATA_W-1:0] ADDR_out,
  output logic                ADDR_WRAP
);

  localparam int PW = 2 * DATA_W;

  typedef logic [DATA_W-1:0] word_t;

  word_t         regs_q [NREGS];
  word_t         regs_d [NREGS];
  word_t         rd_v   [NREGS];
  logic          wrap_q, wrap_d;
  logic          incdec_en;
  logic          wrap_hit;
  logic          load_hits_inc;
  logic [PW-1:0] pair_cur, pair_nxt;

  always_comb begin
    logic [SEL_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    idx           = '0;
    incdec_en     = ADDR_INC ^ ADDR_DEC;
    pair_cur      = {regs_q[{ADDR_INC_SEL, 1'b1}], regs_q[{ADDR_INC_SEL, 1'b0}]};
    pair_nxt      = ADDR_INC ? pair_cur + PW'(1) : pair_cur - PW'(1);
    wrap_hit      = ADDR_INC ? (pair_cur == '1) : (pair_cur == '0);
    load_hits_inc = !ADDR_LOAD_bar && (ADDR_LOAD_SEL == ADDR_INC_SEL);
    // A pair overwritten by ADDR_LOAD never reports a wrap; a single-byte
    // MAIN_LOAD still does, since the other byte keeps the arithmetic result.
    wrap_d        = !RST && incdec_en && wrap_hit && !load_hits_inc;

    for (int i = 0; i < NREGS; i++) begin
      idx       = i[SEL_W-1:0];
      regs_d[i] = regs_q[i];
      if (RST) begin
        regs_d[i] = '0;
      end else if (!ADDR_LOAD_bar && idx[SEL_W-1:1] == ADDR_LOAD_SEL) begin
        regs_d[i] = idx[0] ? ADDR_in[PW-1:DATA_W] : ADDR_in[DATA_W-1:0];
      end else if (!MAIN_LOAD_bar && idx == MAIN_LOAD_SEL) begin
        regs_d[i] = MAIN_in;
      end else if (incdec_en && idx[SEL_W-1:1] == ADDR_INC_SEL) begin
        regs_d[i] = idx[0] ? pair_nxt[PW-1:DATA_W] : pair_nxt[DATA_W-1:0];
      end
      if (ZERO_R0 != 0 && i == 0) begin
        regs_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      // NOTE: this storage is a small flop array, not a RAM macro, so clearing
      // every entry on reset is cheap and is part of the block's contract.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  // Write-through view already reflects reset, so reads return 0 under RST.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rd_v[i] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
    end
  end

  assign MAIN_out  = rd_v[MAIN_ASSERT_SEL];
  assign LHS_out   = rd_v[LHS_ASSERT_SEL];
  assign RHS_out   = rd_v[RHS_ASSERT_SEL];
  assign ADDR_out  = {rd_v[{ADDR_ASSERT_SEL, 1'b1}], rd_v[{ADDR_ASSERT_SEL, 1'b0}]};
  assign ADDR_WRAP = wrap_q;

endmodule

// File: tb/tb_regfile_gen2.sv
// Bench for regfile_gen2: directed scenarios plus random traffic, checked
// against a pair-arithmetic reference model on a bypass and a zero-R0 build.
module tb_regfile_gen2;

  localparam int DW = 8;
  localparam int NR = 8;
  localparam int SW = 3;

  typedef logic [NR-1:0][DW-1:0] regs_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          MAIN_LOAD_bar;
  logic [SW-1:0] MAIN_LOAD_SEL;
  logic [DW-1:0] MAIN_in;
  logic          ADDR_LOAD_bar;
  logic [SW-2:0] ADDR_LOAD_SEL;
  logic [2*DW-1:0] ADDR_in;
  logic          ADDR_INC, ADDR_DEC;
  logic [SW-2:0] ADDR_INC_SEL;
  logic [SW-1:0] MAIN_ASSERT_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
  logic [SW-2:0] ADDR_ASSERT_SEL;

  logic [DW-1:0]   main1, lhs1, rhs1, main0, lhs0, rhs0;
  logic [2*DW-1:0] addr1, addr0;
  logic            wrap1, wrap0;

  int    checks   = 0;
  int    failures = 0;
  regs_t m1, m0, nxt1, nxt0;
  bit    w1, w0;

  always #5 CLK = ~CLK;

  regfile_gen2 #(.DATA_W(DW), .NREGS(NR), .BYPASS(1), .ZERO_R0(0)) u_dut (
    .CLK(CLK), .RST(RST),
    .MAIN_LOAD_bar(MAIN_LOAD_bar), .MAIN_LOAD_SEL(MAIN_LOAD_SEL), .MAIN_in(MAIN_in),
    .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_LOAD_SEL(ADDR_LOAD_SEL), .ADDR_in(ADDR_in),
    .ADDR_INC(ADDR_INC), .ADDR_DEC(ADDR_DEC), .ADDR_INC_SEL(ADDR_INC_SEL),
    .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .LHS_ASSERT_SEL(LHS_ASSERT_SEL),
    .RHS_ASSERT_SEL(RHS_ASSERT_SEL), .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL),
    .MAIN_out(main1), .LHS_out(lhs1), .RHS_out(rhs1), .ADDR_out(addr1),
    .ADDR_WRAP(wrap1)
  );

  regfile_gen2 #(.DATA_W(DW), .NREGS(NR), .BYPASS(0), .ZERO_R0(1)) u_dut_z0 (
    .CLK(CLK), .RST(RST),
    .MAIN_LOAD_bar(MAIN_LOAD_bar), .MAIN_LOAD_SEL(MAIN_LOAD_SEL), .MAIN_in(MAIN_in),
    .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_LOAD_SEL(ADDR_LOAD_SEL), .ADDR_in(ADDR_in),
    .ADDR_INC(ADDR_INC), .ADDR_DEC(ADDR_DEC), .ADDR_INC_SEL(ADDR_INC_SEL),
    .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .LHS_ASSERT_SEL(LHS_ASSERT_SEL),
    .RHS_ASSERT_SEL(RHS_ASSERT_SEL), .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL),
    .MAIN_out(main0), .LHS_out(lhs0), .RHS_out(rhs0), .ADDR_out(addr0),
    .ADDR_WRAP(wrap0)
  );

  task automatic check(input string tag, input logic [2*DW-1:0] got,
                       input logic [2*DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference: treat the selected pair as one integer, then let lower-priority
  // writes be overwritten by higher-priority ones in order.
  function automatic regs_t model_next(input regs_t cur, input bit zr0, output bit wrap);
    regs_t n;
    int    p, pv;
    wrap = 1'b0;
    if (zr0) cur[0] = '0;
    n = cur;
    if (RST) return '0;
    if (ADDR_INC != ADDR_DEC) begin
      p  = int'(ADDR_INC_SEL);
      pv = int'({cur[2*p+1], cur[2*p]});
      if (ADDR_INC) begin
        wrap = (pv == 65535);
        pv   = (pv + 1) % 65536;
      end else begin
        wrap = (pv == 0);
        pv   = (pv + 65535) % 65536;
      end
      n[2*p]   = pv[7:0];
      n[2*p+1] = pv[15:8];
    end
    if (!MAIN_LOAD_bar) n[MAIN_LOAD_SEL] = MAIN_in;
    if (!ADDR_LOAD_bar) begin
      p        = int'(ADDR_LOAD_SEL);
      n[2*p]   = ADDR_in[7:0];
      n[2*p+1] = ADDR_in[15:8];
      if (ADDR_INC != ADDR_DEC && ADDR_LOAD_SEL == ADDR_INC_SEL) wrap = 1'b0;
    end
    if (zr0) n[0] = '0;
    return n;
  endfunction

  task automatic idle();
    RST = 1'b0; MAIN_LOAD_bar = 1'b1; ADDR_LOAD_bar = 1'b1;
    ADDR_INC = 1'b0; ADDR_DEC = 1'b0;
  endtask

  // Reads are checked mid-cycle: bypass build shows post-edge, other pre-edge.
  task automatic settle(input bit chk_rd);
    int a;
    #1;
    nxt1 = model_next(m1, 1'b0, w1);
    nxt0 = model_next(m0, 1'b1, w0);
    a = 2 * int'(ADDR_ASSERT_SEL);
    if (chk_rd) begin
      check("main_byp", 16'(main1), 16'(nxt1[MAIN_ASSERT_SEL]));
      check("lhs_byp",  16'(lhs1),  16'(nxt1[LHS_ASSERT_SEL]));
      check("rhs_byp",  16'(rhs1),  16'(nxt1[RHS_ASSERT_SEL]));
      check("addr_byp", addr1, {nxt1[a+1], nxt1[a]});
      check("main_z0",  16'(main0), 16'(m0[MAIN_ASSERT_SEL]));
      check("lhs_z0",   16'(lhs0),  16'(m0[LHS_ASSERT_SEL]));
      check("rhs_z0",   16'(rhs0),  16'(m0[RHS_ASSERT_SEL]));
      check("addr_z0",  addr0, {m0[a+1], m0[a]});
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    m1 = nxt1;
    m0 = nxt0;
    check("wrap_byp", 16'(wrap1), 16'(w1));
    check("wrap_z0",  16'(wrap0), 16'(w0));
  endtask

  task automatic set_reads(input logic [SW-1:0] s, input logic [SW-2:0] ps);
    MAIN_ASSERT_SEL = s; LHS_ASSERT_SEL = s; RHS_ASSERT_SEL = s; ADDR_ASSERT_SEL = ps;
  endtask

  task automatic addr_load(input logic [SW-2:0] p, input logic [2*DW-1:0] v);
    idle(); ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = p; ADDR_in = v;
    set_reads(3'd0, p);
    settle(1'b1); tick();
  endtask

  initial begin
    m1 = '0; m0 = '0;
    MAIN_LOAD_SEL = '0; MAIN_in = '0; ADDR_LOAD_SEL = '0; ADDR_in = '0;
    ADDR_INC_SEL = '0;
    set_reads(3'd0, 2'd0);

    // Power-up: stored contents are unknown until the first reset edge.
    idle(); RST = 1'b1;
    @(negedge CLK);
    settle(1'b0); tick();

    // Reset state visible on every port.
    idle(); RST = 1'b1; set_reads(3'd5, 2'd2);
    settle(1'b1);
    check("rst_main", 16'(main1), 16'h0000);
    check("rst_addr", addr1, 16'h0000);
    tick();
    check("rst_wrap", 16'(wrap1), 16'h0000);

    // Byte load with write-through, then steady reads on all byte ports.
    idle(); MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd3; MAIN_in = 8'hA5;
    set_reads(3'd3, 2'd1);
    settle(1'b1);
    check("r3_load_cycle", 16'(main1), 16'h00A5);
    tick();
    idle(); settle(1'b1);
    check("r3_lhs", 16'(lhs1), 16'h00A5);
    check("r3_rhs", 16'(rhs1), 16'h00A5);
    check("r3_z0_main", 16'(main0), 16'h00A5);
    tick();

    // Increment wrap and decrement wrap on pair 1.
    addr_load(2'd1, 16'hFFFF);
    idle(); ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd1; set_reads(3'd2, 2'd1);
    settle(1'b1);
    check("inc_wrap_val", addr1, 16'h0000);
    tick();
    check("inc_wrap_flag", 16'(wrap1), 16'h0001);
    idle(); settle(1'b1); tick();
    check("wrap_one_cycle", 16'(wrap1), 16'h0000);
    idle(); ADDR_DEC = 1'b1; ADDR_INC_SEL = 2'd1;
    settle(1'b1);
    check("dec_wrap_val", addr1, 16'hFFFF);
    tick();
    check("dec_wrap_flag", 16'(wrap1), 16'h0001);

    // Increment with a byte load into the low half of the same pair.
    addr_load(2'd2, 16'h12FF);
    idle(); ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd2;
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd4; MAIN_in = 8'h77;
    set_reads(3'd4, 2'd2);
    settle(1'b1);
    check("inc_with_main", addr1, 16'h1377);
    tick();

    // Opposing inc/dec, then pair load overriding inc.
    addr_load(2'd0, 16'h0100);
    idle(); ADDR_INC = 1'b1; ADDR_DEC = 1'b1; ADDR_INC_SEL = 2'd0;
    set_reads(3'd1, 2'd0);
    settle(1'b1);
    check("inc_dec_hold", addr1, 16'h0100);
    tick();
    check("inc_dec_nowrap", 16'(wrap1), 16'h0000);
    idle(); ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd0;
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd0; ADDR_in = 16'hBEEF;
    settle(1'b1);
    check("load_over_inc", addr1, 16'hBEEF);
    check("load_over_inc_z0", addr0, 16'h0100);
    tick();

    // Reset in the middle of continuous increments on pair 3.
    addr_load(2'd3, 16'h0005);
    idle(); ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd3; set_reads(3'd6, 2'd3);
    settle(1'b1); tick();
    settle(1'b1); tick();
    RST = 1'b1;
    settle(1'b1);
    check("rst_during_inc", addr1, 16'h0000);
    tick();
    RST = 1'b0;
    settle(1'b1);
    check("inc_after_rst", addr1, 16'h0001);
    tick();

    // Random traffic with pair loads biased toward the wrap boundaries.
    for (int n = 0; n < 400; n++) begin
      RST           = ($urandom_range(31) == 0);
      MAIN_LOAD_bar = 1'($urandom_range(1));
      MAIN_LOAD_SEL = SW'($urandom);
      MAIN_in       = DW'($urandom);
      ADDR_LOAD_bar = ($urandom_range(3) != 0);
      ADDR_LOAD_SEL = (SW-1)'($urandom);
      case ($urandom_range(3))
        0:       ADDR_in = 16'hFFFF;
        1:       ADDR_in = 16'h0000;
        default: ADDR_in = 16'($urandom);
      endcase
      ADDR_INC        = 1'($urandom_range(1));
      ADDR_DEC        = 1'($urandom_range(1));
      ADDR_INC_SEL    = (SW-1)'($urandom);
      MAIN_ASSERT_SEL = SW'($urandom);
      LHS_ASSERT_SEL  = SW'($urandom);
      RHS_ASSERT_SEL  = SW'($urandom);
      ADDR_ASSERT_SEL = (SW-1)'($urandom);
      settle(1'b1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/regfile_gen2.md
REGFILE_GEN2 -- requirements
Module: regfile_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8; width of each general register and of the MAIN/LHS/RHS buses.
REQ-002 SHALL have parameter NREGS, default 8; register count, power of two, minimum 4; SEL_W = log2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1; 1 = read ports forward same-cycle write data, 0 = read ports show stored value only.
REQ-004 SHALL have parameter ZERO_R0, default 0; 1 = register 0 reads as 0 and ignores writes.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 MAIN_LOAD_bar  in  1  active-low byte write enable.
REQ-008 MAIN_LOAD_SEL  in  SEL_W  byte write target register.
REQ-009 MAIN_in  in  DATA_W  byte write data.
REQ-010 ADDR_LOAD_bar  in  1  active-low pair write enable.
REQ-011 ADDR_LOAD_SEL  in  SEL_W-1  pair write target; pair k = {R[2k+1], R[2k]}.
REQ-012 ADDR_in  in  2*DATA_W  pair write data.
REQ-013 ADDR_INC  in  1  active-high increment of selected pair.
REQ-014 ADDR_DEC  in  1  active-high decrement of selected pair.
REQ-015 ADDR_INC_SEL  in  SEL_W-1  pair targeted by ADDR_INC/ADDR_DEC.
REQ-016 MAIN_ASSERT_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL  in  SEL_W each  byte read selects.
REQ-017 ADDR_ASSERT_SEL  in  SEL_W-1  pair read select.
REQ-018 MAIN_out, LHS_out, RHS_out  out  DATA_W each  byte read data, always driven.
REQ-019 ADDR_out  out  2*DATA_W  pair read data, always driven.
REQ-020 ADDR_WRAP  out  1  registered one-cycle pulse flagging pair wrap-around.

Function
REQ-021 Read ports SHALL be combinational from the selects; three byte reads plus one pair read per cycle, no port interference.
REQ-022 ADDR_INC=1, ADDR_DEC=0 SHALL store pair+1 mod 2^(2*DATA_W) at next edge; ADDR_DEC=1, ADDR_INC=0 SHALL store pair-1 mod 2^(2*DATA_W).
REQ-023 ADDR_INC and ADDR_DEC both 1 SHALL leave the pair unchanged and not raise ADDR_WRAP.
REQ-024 ADDR_WRAP SHALL be 1 in the cycle after an applied increment from all-ones or applied decrement from zero, else 0.
REQ-025 Per-byte write priority SHALL be ADDR_LOAD > MAIN_LOAD > INC/DEC; a suppressed INC/DEC SHALL NOT raise ADDR_WRAP.
REQ-026 MAIN_LOAD on one byte of a pair under INC/DEC: that byte takes MAIN_in, the other byte takes its half of the inc/dec result; wrap reported from the full pair arithmetic.
REQ-027 ADDR_LOAD and INC/DEC on the same pair: pair takes ADDR_in, no ADDR_WRAP.
REQ-028 Writes to distinct registers in the same cycle SHALL all take effect.
REQ-029 BYPASS=1: each read port SHALL return the value the selected register(s) will hold after the current edge, including inc/dec results; BYPASS=0: pre-edge value.
REQ-030 ZERO_R0=1: R0 SHALL read 0 on all ports, pair 0 SHALL read {R1, 0}, inc/dec of pair 0 SHALL update only R1 with the computed upper byte.

Reset
REQ-031 RST=1 at an edge SHALL clear all registers and ADDR_WRAP to 0, overriding every write/inc/dec that cycle.
REQ-032 Under RST=1 with BYPASS=1, read ports SHALL return 0; first write takes effect at the first edge with RST=0.

Verification
REQ-033 RST 1 cycle, all reads -> MAIN_out=LHS_out=RHS_out=0x00, ADDR_out=0x0000, ADDR_WRAP=0.
REQ-034 MAIN load R3=0xA5, next cycle LHS_SEL=3, RHS_SEL=3, MAIN_SEL=3 -> all 0xA5; BYPASS=1 shows 0xA5 in the load cycle itself.
REQ-035 ADDR load pair1=0xFFFF, ADDR_INC pair1 -> ADDR_out=0x0000, ADDR_WRAP=1 for exactly one cycle; ADDR_DEC -> 0xFFFF, ADDR_WRAP=1.
REQ-036 Pair2=0x12FF, ADDR_INC pair2 plus MAIN load R4=0x77 same cycle -> pair2=0x1377.
REQ-037 ADDR_INC and ADDR_DEC together on pair0=0x0100 -> unchanged, ADDR_WRAP=0; ADDR_LOAD 0xBEEF plus ADDR_INC same pair -> 0xBEEF.
REQ-038 RST asserted during continuous ADDR_INC on pair3=0x0005 -> pair3=0x0000 after that edge, increments resume after RST drops.
